lrm_seq: RTL

Load-request sequencer for strided vector loads. Accepts one vector load command (base address, element width, stride code, element count), splits it into 64-byte line requests, and tags each request with the sequence ID that the load response packer uses to place response bytes. It tracks outstanding line responses and reports command completion. It sits between the vector issue stage and the memory request port, upstream of the response packer.

---
 rtl/lrm_seq.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/lrm_seq.sv
// lrm_seq: load-request sequencer for strided vector loads.
//
// Takes one vector load command (base address, element width, stride code,
// element count), walks it one 64-byte line at a time and emits one line
// request per line touched. Each request carries a sequence ID that tells the
// response packer how many elements the line holds, where the first one sits,
// which element index it is and which line of the command it is. Line
// responses are counted back in and a one-cycle done pulse closes the command.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   cmd_valid / cmd_ready   command handshake (ready only when idle)
//   cmd_addr[39:0]          byte address of element 0
//   cmd_eew[1:0]            element width, log2 bytes
//   cmd_stride[2:0]         stride code: [1:0] log2 elements, [2] negative
//   cmd_vl[10:0]            element count 0..1024
//   cmd_id[4:0]             command tag returned on done_id
//   req_valid / req_ready   line request handshake
//   req_line[33:0]          line address (element address [39:6])
//   req_seq_id[33:0]        {id, nelem, off, idx, line}
//   rsp_valid               one line response returned
//   done_valid              one-cycle completion pulse
//   done_id, done_err       tag and reject flag of the completed command
//   dbg_state[1:0]          FSM state: 0 idle, 1 issue, 2 drain, 3 done
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. A source that raises valid keeps it high and keeps its
// payload unchanged until the transfer happens; valid never depends on ready.

module lrm_seq #(
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [39:0] cmd_addr,
  input  logic [1:0]  cmd_eew,
  input  logic [2:0]  cmd_stride,
  input  logic [10:0] cmd_vl,
  input  logic [4:0]  cmd_id,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [33:0] req_line,
  output logic [33:0] req_seq_id,
  input  logic        rsp_valid,
  output logic        done_valid,
  output logic [4:0]  done_id,
  output logic        done_err,
  output logic [1:0]  dbg_state
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [39:0]     cur_addr_q;
  logic [10:0]     rem_q;
  logic [10:0]     idx_q;
  logic [4:0]      line_q;
  logic [2:0]      bs_q;      // log2 of the byte stride
  logic            neg_q;
  logic [4:0]      id_q;
  logic [OW-1:0]   outstanding_q;
  logic [4:0]      done_id_q;
  logic            done_err_q;

  logic            cmd_acc;
  logic [2:0]      align_mask;
  logic            cmd_err;
  logic [5:0]      off;
  logic [5:0]      span;
  logic [6:0]      room;
  logic [6:0]      nelem;
  logic [11:0]     step;
  logic [39:0]     next_addr;
  logic            req_fire;
  logic            rsp_take;
  logic            last_req;
  logic            done_enter;

  // ---------------------------------------------------------------------
  // Command decode
  // ---------------------------------------------------------------------
  assign cmd_acc = cmd_valid & cmd_ready;

  always_comb begin
    align_mask = 3'b000;
    case (cmd_eew)
      2'd0:    align_mask = 3'b000;
      2'd1:    align_mask = 3'b001;
      2'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  end

  // Stride codes 3 and 7 are reserved; misaligned element 0 is rejected.
  assign cmd_err = (cmd_stride[1:0] == 2'b11) | (|(cmd_addr[2:0] & align_mask));

  // ---------------------------------------------------------------------
  // Per-line request datapath
  // ---------------------------------------------------------------------
  assign off = cur_addr_q[5:0];
  // Bytes left in the line in the walking direction, minus one.
  assign span = neg_q ? off : ~off;
  assign room = {1'b0, (span >> bs_q)} + 7'd1;
  assign nelem = (rem_q < {4'b0, room}) ? rem_q[6:0] : room;
  assign step = {5'b0, nelem} << bs_q;
  assign next_addr = neg_q ? (cur_addr_q - {28'b0, step})
                           : (cur_addr_q + {28'b0, step});

  assign req_fire = req_valid & req_ready;
  // A response with nothing in flight is dropped.
  assign rsp_take = rsp_valid & (outstanding_q != '0);
  assign last_req = (rem_q == {4'b0, nelem});

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_acc) begin
          if (cmd_err || (cmd_vl == 11'd0)) state_d = S_DONE;
          else                              state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (req_fire && last_req) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // The final response may arrive in the cycle it is checked.
        if ((outstanding_q == '0) ||
            ((outstanding_q == OW'(1)) && rsp_take)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cmd_ready  = (state_q == S_IDLE);
    req_valid  = (state_q == S_ISSUE) && (outstanding_q < MAX_OUT);
    done_valid = (state_q == S_DONE);
  end

  // ---------------------------------------------------------------------
  // Command walk registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_addr_q <= '0;
      rem_q      <= '0;
      idx_q      <= '0;
      line_q     <= '0;
      bs_q       <= '0;
      neg_q      <= 1'b0;
      id_q       <= '0;
    end else if (cmd_acc) begin
      cur_addr_q <= cmd_addr;
      rem_q      <= cmd_vl;
      idx_q      <= '0;
      line_q     <= '0;
      bs_q       <= {1'b0, cmd_eew} + {1'b0, cmd_stride[1:0]};
      neg_q      <= cmd_stride[2];
      id_q       <= cmd_id;
    end else if (req_fire) begin
      cur_addr_q <= next_addr;
      rem_q      <= rem_q - {4'b0, nelem};
      idx_q      <= idx_q + {4'b0, nelem};
      line_q     <= line_q + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding_q <= '0;
    end else begin
      case ({req_fire, rsp_take})
        2'b10:   outstanding_q <= outstanding_q + OW'(1);
        2'b01:   outstanding_q <= outstanding_q - OW'(1);
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  // Done tag/flag are captured on entry to DONE and held afterwards. A
  // command that goes straight from IDLE to DONE has not been latched yet,
  // so its tag comes from the command port.
  assign done_enter = (state_d == S_DONE) && (state_q != S_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_id_q  <= '0;
      done_err_q <= 1'b0;
    end else if (done_enter) begin
      done_id_q  <= (state_q == S_IDLE) ? cmd_id : id_q;
      done_err_q <= (state_q == S_IDLE) & cmd_err;
    end
  end

  assign req_line   = cur_addr_q[39:6];
  assign req_seq_id = {id_q, nelem, off, idx_q, line_q};
  assign done_id    = done_id_q;
  assign done_err   = done_err_q;
  assign dbg_state  = state_q;

  rsp_without_outstanding: assert property (
    @(posedge clk) disable iff (!reset_n) !(rsp_valid && (outstanding_q == '0))
  );

endmodule
